ex_stage_pipe: RTL and testbench

//  Parametrised execute stage and EX/MEM pipeline register; successor to the fixed-width execute/memory stage.
//  - Operand select and ALU via the existing mux_1/alu instances.
//  - Resolves all six RV32I conditional branches plus JAL/JALR locally.
//  - Valid/ready handshake with back-pressure from MEM.
//  - Issues a registered one-cycle PC redirect and squashes the wrong-path slot.
//  - External flush. Sits between decode/issue and the memory stage.

---
 rtl/ex_stage_pipe_if.sv | 64 ++++++
 rtl/ex_stage_pipe.sv | 154 +++++++++++++++
 tb/tb_ex_stage_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_if.sv
// ALU opcode package and the execute-stage bundle: issue side (E), memory side (M) and PC redirect.
package ex_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;
endpackage

interface ex_stage_pipe_if #(
    parameter int DPW = 32,
    parameter int ADW = 5
) ();
    logic                   flush_i;
    logic                   validE;
    logic                   readyE;
    logic                   regwriteE;
    logic                   resultsrcE;
    logic                   memwriteE;
    logic                   branchE;
    logic                   jumpE;
    logic                   jalrE;
    logic [2:0]             funct3E;
    logic                   alusrcE;
    ex_stage_pkg::alu_op_t  alu_ctrlE;
    logic [DPW-1:0]         srcA;
    logic [DPW-1:0]         Rd2E;
    logic [ADW-1:0]         RdE;
    logic [DPW-1:0]         immextE;
    logic [DPW-1:0]         PCE;
    logic                   validM;
    logic                   readyM;
    logic                   regwriteM;
    logic                   resultsrcM;
    logic                   memwriteM;
    logic [DPW-1:0]         aluresultM;
    logic [DPW-1:0]         Rd2M;
    logic [ADW-1:0]         RdM;
    logic                   redirect_o;
    logic [DPW-1:0]         pc_target_o;

    // The execute stage itself.
    modport slave (
        input  flush_i, validE, regwriteE, resultsrcE, memwriteE, branchE, jumpE, jalrE,
               funct3E, alusrcE, alu_ctrlE, srcA, Rd2E, RdE, immextE, PCE, readyM,
        output readyE, validM, regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
               redirect_o, pc_target_o
    );

    // Decode/issue plus memory stage as seen from outside.
    modport master (
        output flush_i, validE, regwriteE, resultsrcE, memwriteE, branchE, jumpE, jalrE,
               funct3E, alusrcE, alu_ctrlE, srcA, Rd2E, RdE, immextE, PCE, readyM,
        input  readyE, validM, regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM,
               redirect_o, pc_target_o
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage with EX/MEM pipeline register: operand mux, ALU, local branch/jump resolution,
// valid/ready back-pressure, registered one-cycle PC redirect with wrong-path squash, and flush.
module mux_1 #(
    parameter int DPW = 32
) (
    input  logic [DPW-1:0] d0,
    input  logic [DPW-1:0] d1,
    input  logic           sel,
    output logic [DPW-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module alu import ex_stage_pkg::*; #(
    parameter int DPW = 32
) (
    input  logic [DPW-1:0] a,
    input  logic [DPW-1:0] b,
    input  alu_op_t        op,
    output logic [DPW-1:0] y
);
    localparam int SHW = $clog2(DPW);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        // NOTE: default assigned before the case so no path leaves y unassigned (no latch).
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {{(DPW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(DPW-1){1'b0}}, a < b};
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            default:  y = '0;
        endcase
    end
endmodule

module ex_stage_pipe #(
    parameter int DPW      = 32,
    parameter int ADW      = 5,
    parameter int LINK_INC = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    ex_stage_pipe_if.slave  bus
);
    logic [DPW-1:0] src_b;
    logic [DPW-1:0] alu_y;
    logic [DPW-1:0] target;
    logic [DPW-1:0] result;
    logic           cond;
    logic           taken;
    logic           accept;

    logic           valid_q;
    logic           regwrite_q;
    logic           resultsrc_q;
    logic           memwrite_q;
    logic [DPW-1:0] aluresult_q;
    logic [DPW-1:0] rd2_q;
    logic [ADW-1:0] rd_q;
    logic           redirect_q;
    logic [DPW-1:0] pc_target_q;

    mux_1 #(.DPW(DPW)) u_srcb_mux (
        .d0  (bus.Rd2E),
        .d1  (bus.immextE),
        .sel (bus.alusrcE),
        .y   (src_b)
    );

    alu #(.DPW(DPW)) u_alu (
        .a  (bus.srcA),
        .b  (src_b),
        .op (bus.alu_ctrlE),
        .y  (alu_y)
    );

    // Branch compares always use rs2 data, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (bus.funct3E)
            3'b000:  cond = (bus.srcA == bus.Rd2E);
            3'b001:  cond = (bus.srcA != bus.Rd2E);
            3'b100:  cond = ($signed(bus.srcA) <  $signed(bus.Rd2E));
            3'b101:  cond = ($signed(bus.srcA) >= $signed(bus.Rd2E));
            3'b110:  cond = (bus.srcA <  bus.Rd2E);
            3'b111:  cond = (bus.srcA >= bus.Rd2E);
            default: cond = 1'b0;
        endcase
    end

    assign taken  = (bus.branchE && cond) || bus.jumpE;
    assign target = bus.jalrE ? ((bus.srcA + bus.immextE) & ~DPW'(1))
                              : (bus.PCE + bus.immextE);
    assign result = bus.jumpE ? (bus.PCE + DPW'(LINK_INC)) : alu_y;

    // The slot presented during a redirect cycle is wrong-path: drained but never accepted.
    assign bus.readyE = !valid_q || bus.readyM;
    assign accept     = bus.validE && bus.readyE && !bus.flush_i && !redirect_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: data fields are reset as well, so every output reads 0 straight out of reset.
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            aluresult_q <= '0;
            rd2_q       <= '0;
            rd_q        <= '0;
            redirect_q  <= 1'b0;
            pc_target_q <= '0;
        end else begin
            redirect_q <= accept && taken;
            if (accept && taken) begin
                pc_target_q <= target;
            end

            if (bus.flush_i) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q     <= 1'b1;
                regwrite_q  <= bus.regwriteE;
                resultsrc_q <= bus.resultsrcE;
                memwrite_q  <= bus.memwriteE;
                aluresult_q <= result;
                rd2_q       <= bus.Rd2E;
                rd_q        <= bus.RdE;
            end else if (bus.readyM) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.validM      = valid_q;
    assign bus.regwriteM   = regwrite_q && valid_q;
    assign bus.memwriteM   = memwrite_q && valid_q;
    assign bus.resultsrcM  = resultsrc_q;
    assign bus.aluresultM  = aluresult_q;
    assign bus.Rd2M        = rd2_q;
    assign bus.RdM         = rd_q;
    assign bus.redirect_o  = redirect_q;
    assign bus.pc_target_o = pc_target_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed instructions push hand-computed results and redirect
// targets; a monitor pops and compares on every MEM transfer and every redirect pulse.
module tb_ex_stage_pipe;
    import ex_stage_pkg::*;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a, b, imm, pc;
        logic        alusrc;
        logic [4:0]  rd;
        logic        rw, rs, mw, br, jmp, jalr;
        logic [2:0]  f3;
    } ins_t;

    typedef struct {
        logic [31:0] alu, rd2;
        logic [4:0]  rd;
        logic        rw, rs, mw;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, alu;
        bit          tk;
    } br_vec_t;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;
    exp_t        exp_q[$];
    logic [31:0] tgt_q[$];
    exp_t        got;
    logic        prev_redir;
    longint      t0, t1;
    br_vec_t     bv[7];

    ex_stage_pipe_if #(.DPW(32), .ADW(5)) bus ();

    ex_stage_pipe #(.DPW(32), .ADW(5), .LINK_INC(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [31:0] pc, logic alusrc, logic [4:0] rd, logic rw,
                                logic rs, logic mw, logic br, logic jmp, logic jalr,
                                logic [2:0] f3);
        ins_t i;
        i.op = op; i.a = a; i.b = b; i.imm = imm; i.pc = pc; i.alusrc = alusrc; i.rd = rd;
        i.rw = rw; i.rs = rs; i.mw = mw; i.br = br; i.jmp = jmp; i.jalr = jalr; i.f3 = f3;
        return i;
    endfunction

    function automatic exp_t mkexp(logic [31:0] alu, logic [31:0] rd2, logic [4:0] rd,
                                   logic rw, logic rs, logic mw);
        exp_t e;
        e.alu = alu; e.rd2 = rd2; e.rd = rd; e.rw = rw; e.rs = rs; e.mw = mw;
        return e;
    endfunction

    task automatic drive(input ins_t i);
        bus.validE     = 1'b1;
        bus.alu_ctrlE  = i.op;
        bus.srcA       = i.a;
        bus.Rd2E       = i.b;
        bus.immextE    = i.imm;
        bus.PCE        = i.pc;
        bus.alusrcE    = i.alusrc;
        bus.RdE        = i.rd;
        bus.regwriteE  = i.rw;
        bus.resultsrcE = i.rs;
        bus.memwriteE  = i.mw;
        bus.branchE    = i.br;
        bus.jumpE      = i.jmp;
        bus.jalrE      = i.jalr;
        bus.funct3E    = i.f3;
    endtask

    task automatic bus_idle();
        drive(mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        bus.validE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_idle();
        end
    endtask

    // Holds the instruction until the handshake takes it, then records what MEM should see.
    task automatic send(input ins_t i, input exp_t e, input bit push, input bit tk,
                        input logic [31:0] tgt);
        bit done;
        done = 1'b0;
        @(negedge clk);
        drive(i);
        for (int n = 0; n < 40 && !done; n++) begin
            #4;
            done = bus.readyE && !bus.redirect_o && !bus.flush_i;
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instruction pc=%0h not accepted within 40 cycles", i.pc);
        end else if (push) begin
            exp_q.push_back(e);
            if (tk) tgt_q.push_back(tgt);
        end
    endtask

    // Presents a wrong-path slot during the redirect cycle; it must be drained but not accepted.
    task automatic wrong_path();
        @(negedge clk);
        drive(mk(ALU_ADD, 32'h55, 32'h66, 0, 32'hDEAD0, 0, 5'd7, 1, 0, 1, 0, 0, 0, 3'b000));
        #4;
        check("redirect_pulse", bus.redirect_o, 1);
        check("readyE_in_redirect", bus.readyE, 1);
        @(posedge clk);
    endtask

    // Monitor: compares on every MEM transfer and on every redirect pulse.
    always @(negedge clk) begin
        #4;
        if (arst_n) begin
            if (bus.validM && bus.readyM) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_validM: aluresultM=%0h with no pending entry at %0t",
                             bus.aluresultM, $time);
                end else begin
                    got = exp_q.pop_front();
                    check("aluresultM", bus.aluresultM, got.alu);
                    check("Rd2M", bus.Rd2M, got.rd2);
                    check("ctrlM", {bus.RdM, bus.regwriteM, bus.resultsrcM, bus.memwriteM},
                          {got.rd, got.rw, got.rs, got.mw});
                end
            end
            if (bus.redirect_o) begin
                check("redirect_single_cycle", prev_redir, 0);
                if (tgt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: pc_target_o=%0h at %0t", bus.pc_target_o, $time);
                end else begin
                    check("pc_target_o", bus.pc_target_o, tgt_q.pop_front());
                end
            end
        end
        prev_redir = bus.redirect_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        prev_redir = 1'b0;
        arst_n     = 1'b0;
        bus.readyM  = 1'b1;
        bus.flush_i = 1'b0;
        bus_idle();

        #3;
        check("reset_validM", bus.validM, 0);
        check("reset_ctrl", {bus.regwriteM, bus.resultsrcM, bus.memwriteM, bus.redirect_o}, 0);
        check("reset_data", {bus.aluresultM, bus.Rd2M}, 0);
        check("reset_rd_target", {bus.RdM, bus.pc_target_o}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        idle(1);

        // ADD stream and mixed ALU traffic, one instruction per cycle.
        send(mk(ALU_ADD, 5, 7, 0, 32'h10, 0, 3, 1, 0, 0, 0, 0, 0, 0), mkexp(12, 7, 3, 1, 0, 0), 1, 0, 0);
        t0 = longint'($time);
        send(mk(ALU_ADD, 5, 7, 32'h10, 32'h14, 1, 4, 1, 0, 0, 0, 0, 0, 0), mkexp(32'h15, 7, 4, 1, 0, 0), 1, 0, 0);
        send(mk(ALU_SUB, 100, 1, 0, 32'h18, 0, 0, 0, 0, 1, 0, 0, 0, 0), mkexp(99, 1, 0, 0, 0, 1), 1, 0, 0);
        send(mk(ALU_ADD, 32'h1000, 32'hAA, 8, 32'h1C, 1, 9, 1, 1, 0, 0, 0, 0, 0), mkexp(32'h1008, 32'hAA, 9, 1, 1, 0), 1, 0, 0);
        send(mk(ALU_XOR, 32'hF0, 32'hFF, 0, 32'h20, 0, 2, 1, 0, 0, 0, 0, 0, 0), mkexp(32'h0F, 32'hFF, 2, 1, 0, 0), 1, 0, 0);
        t1 = longint'($time);
        check("add_throughput", t1 - t0, 40);
        idle(2);

        // Back-pressure: MEM stalls for three cycles while a second instruction waits.
        @(negedge clk);
        bus.readyM = 1'b0;
        send(mk(ALU_ADD, 10, 20, 0, 32'h30, 0, 5, 1, 0, 0, 0, 0, 0, 0), mkexp(30, 20, 5, 1, 0, 0), 1, 0, 0);
        fork
            send(mk(ALU_ADD, 3, 4, 0, 32'h34, 0, 6, 1, 0, 0, 0, 0, 0, 0), mkexp(7, 4, 6, 1, 0, 0), 1, 0, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #4;
                    check("stall_readyE", bus.readyE, 0);
                    check("stall_hold", {bus.validM, bus.regwriteM, bus.RdM, bus.aluresultM},
                          {1'b1, 1'b1, 5'd5, 32'd30});
                end
                @(negedge clk);
                bus.readyM = 1'b1;
            end
        join
        idle(2);

        // BLT taken with a squashed wrong-path slot; BLTU not taken; BGEU taken.
        send(mk(ALU_SUB, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 3'b100),
             mkexp(32'hFFFFFFFE, 1, 0, 0, 0, 0), 1, 1, 32'h120);
        wrong_path();
        idle(1);
        send(mk(ALU_SUB, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 3'b110),
             mkexp(32'hFFFFFFFE, 1, 0, 0, 0, 0), 1, 0, 0);
        idle(1);
        #4;
        check("bltu_no_redirect", bus.redirect_o, 0);
        send(mk(ALU_SUB, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 3'b111),
             mkexp(32'hFFFFFFFE, 1, 0, 0, 0, 0), 1, 1, 32'h120);
        wrong_path();
        idle(1);

        // All branch conditions, plus an unused funct3 that must never be taken.
        bv[0] = '{3'b000, 32'd7,        32'd7,        32'd14,       1'b1};
        bv[1] = '{3'b001, 32'd7,        32'd7,        32'd14,       1'b0};
        bv[2] = '{3'b100, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        bv[3] = '{3'b101, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFF6, 1'b1};
        bv[4] = '{3'b110, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        bv[5] = '{3'b111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        bv[6] = '{3'b010, 32'd1,        32'd2,        32'd3,        1'b0};
        for (int k = 0; k < 7; k++) begin
            send(mk(ALU_ADD, bv[k].a, bv[k].b, 32'h10, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0, bv[k].f3),
                 mkexp(bv[k].alu, bv[k].b, 0, 0, 0, 0), 1, bv[k].tk, 32'h310);
            if (bv[k].tk) begin
                wrong_path();
                idle(1);
            end else begin
                idle(1);
                #4;
                check("branch_not_taken", bus.redirect_o, 0);
            end
        end

        // Jumps: JALR clears bit 0 of the target, JAL links PC+4, and the target wraps.
        send(mk(ALU_ADD, 32'h1003, 0, 0, 32'h40, 1, 1, 1, 0, 0, 0, 1, 1, 0),
             mkexp(32'h44, 0, 1, 1, 0, 0), 1, 1, 32'h1002);
        wrong_path();
        idle(1);
        send(mk(ALU_ADD, 0, 0, 32'h100, 32'h80, 1, 1, 1, 0, 0, 0, 1, 0, 0),
             mkexp(32'h84, 0, 1, 1, 0, 0), 1, 1, 32'h180);
        idle(2);
        send(mk(ALU_ADD, 0, 0, 32'h20, 32'hFFFFFFF0, 1, 8, 1, 0, 0, 0, 1, 0, 0),
             mkexp(32'hFFFFFFF4, 0, 8, 1, 0, 0), 1, 1, 32'h10);
        idle(2);

        // Flush with a held EX/MEM entry and a taken BEQ in the EX slot.
        @(negedge clk);
        bus.readyM = 1'b0;
        send(mk(ALU_ADD, 1, 1, 0, 32'h500, 0, 4, 1, 0, 0, 0, 0, 0, 0), mkexp(2, 1, 4, 1, 0, 0), 0, 0, 0);
        @(negedge clk);
        drive(mk(ALU_ADD, 5, 5, 32'h40, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus_idle();
        bus.flush_i = 1'b0;
        bus.readyM  = 1'b1;
        #4;
        check("flush_held_validM", bus.validM, 0);
        check("flush_held_outputs", {bus.redirect_o, bus.regwriteM, bus.memwriteM}, 0);

        // Flush against a taken BEQ that would otherwise be accepted.
        @(negedge clk);
        drive(mk(ALU_ADD, 5, 5, 32'h40, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus_idle();
        bus.flush_i = 1'b0;
        #4;
        check("flush_taken_validM", bus.validM, 0);
        check("flush_taken_redirect", bus.redirect_o, 0);
        idle(1);

        // Reset mid-stream with a transfer completing and a jump redirect pending.
        send(mk(ALU_ADD, 8, 9, 0, 32'h700, 0, 10, 1, 0, 0, 0, 0, 0, 0), mkexp(17, 9, 10, 1, 0, 0), 1, 0, 0);
        send(mk(ALU_ADD, 0, 32'h33, 32'h80, 32'h704, 1, 1, 1, 0, 1, 0, 1, 0, 0), mkexp(0, 0, 0, 0, 0, 0), 0, 0, 0);
        #2;
        arst_n = 1'b0;
        #1;
        check("rst_mid_validM_redirect", {bus.validM, bus.redirect_o}, 0);
        check("rst_mid_ctrl", {bus.regwriteM, bus.resultsrcM, bus.memwriteM, bus.RdM}, 0);
        check("rst_mid_data", {bus.aluresultM, bus.Rd2M}, 0);
        check("rst_mid_target", bus.pc_target_o, 0);
        @(negedge clk);
        bus_idle();
        arst_n = 1'b1;
        idle(1);
        send(mk(ALU_ADD, 2, 3, 0, 32'h800, 0, 11, 1, 0, 0, 0, 0, 0, 0), mkexp(5, 3, 11, 1, 0, 0), 1, 0, 0);
        idle(5);

        check("scoreboard_drained", exp_q.size(), 0);
        check("redirects_drained", tgt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
